// File: rtl/m_stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear FSM driving a BCD MM:SS.cc
// counter that advances on each rising edge of the external 10 ms strobe.
module m_stopwatch_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk10ms,
   input  logic       btn_ss,
   input  logic       btn_lc,
   output logic       gen_rst,
   output logic       running,
   output logic [7:0] disp_min,
   output logic [7:0] disp_sec,
   output logic [7:0] disp_cs,
   output logic       lap_hold,
   output logic       ovf
);

   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

   state_t      state;
   state_t      next_state;
   logic        clk10ms_q;
   logic        tick;
   logic        inc_en;
   logic        clear_count;
   logic        wrap;
   // Packed as {min tens, min ones, sec tens, sec ones, cs tens, cs ones}
   logic [23:0] count;
   logic [23:0] next_count;

   // Start/stop always wins over lap/clear when both arrive together
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (btn_ss) next_state = RUN;
         RUN: begin
            if (btn_ss)      next_state = STOP;
            else if (btn_lc) next_state = LAP;
         end
         LAP: begin
            if (btn_ss)      next_state = STOP;
            else if (btn_lc) next_state = RUN;
         end
         STOP: begin
            if (btn_ss)      next_state = RUN;
            else if (btn_lc) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign tick        = clk10ms & ~clk10ms_q;
   assign inc_en      = tick & ((state == RUN) | (state == LAP));
   assign clear_count = (state == STOP) & (next_state == IDLE);

   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      if (count[3:0] != 4'd9) begin
         next_count[3:0] = count[3:0] + 4'd1;
      end else begin
         next_count[3:0] = 4'd0;
         if (count[7:4] != 4'd9) begin
            next_count[7:4] = count[7:4] + 4'd1;
         end else begin
            next_count[7:4] = 4'd0;
            if (count[11:8] != 4'd9) begin
               next_count[11:8] = count[11:8] + 4'd1;
            end else begin
               next_count[11:8] = 4'd0;
               if (count[15:12] != 4'd5) begin
                  next_count[15:12] = count[15:12] + 4'd1;
               end else begin
                  next_count[15:12] = 4'd0;
                  if (count[19:16] != 4'd9) begin
                     next_count[19:16] = count[19:16] + 4'd1;
                  end else begin
                     next_count[19:16] = 4'd0;
                     if (count[23:20] != 4'd5) begin
                        next_count[23:20] = count[23:20] + 4'd1;
                     end else begin
                        next_count[23:20] = 4'd0;
                        wrap              = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         clk10ms_q <= 1'b0;
         count     <= 24'h000000;
      end else begin
         state     <= next_state;
         clk10ms_q <= clk10ms;
         if (clear_count)
            count <= 24'h000000;
         else if (inc_en)
            count <= next_count;
      end
   end

   // Display copies the pre-edge count, so entering LAP freezes the value
   // held before any coincident increment; it stays frozen while in LAP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gen_rst  <= 1'b0;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         ovf      <= 1'b0;
         disp_min <= 8'h00;
         disp_sec <= 8'h00;
         disp_cs  <= 8'h00;
      end else begin
         gen_rst  <= (next_state != IDLE);
         running  <= (next_state == RUN) | (next_state == LAP);
         lap_hold <= (next_state == LAP);
         ovf      <= inc_en & wrap;
         if (state != LAP) begin
            disp_min <= count[23:16];
            disp_sec <= count[15:8];
            disp_cs  <= count[7:0];
         end
      end
   end

endmodule

// File: tb/tb_m_stopwatch_ctrl.sv
// Directed bench for m_stopwatch_ctrl: one task per scenario with inline
// comparisons against hand-computed MM:SS.cc values.
module tb_m_stopwatch_ctrl;

   logic        clk;
   logic        rst;
   logic        clk10ms;
   logic        btn_ss;
   logic        btn_lc;
   logic        gen_rst;
   logic        running;
   logic [7:0]  disp_min;
   logic [7:0]  disp_sec;
   logic [7:0]  disp_cs;
   logic        lap_hold;
   logic        ovf;
   logic [23:0] disp_all;
   logic [23:0] preload_val;
   int          checks;
   int          errors;

   assign disp_all = {disp_min, disp_sec, disp_cs};

   m_stopwatch_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .clk10ms  (clk10ms),
      .btn_ss   (btn_ss),
      .btn_lc   (btn_lc),
      .gen_rst  (gen_rst),
      .running  (running),
      .disp_min (disp_min),
      .disp_sec (disp_sec),
      .disp_cs  (disp_cs),
      .lap_hold (lap_hold),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Drive one clk cycle of inputs; returns 1 time unit after the edge
   task automatic applyStimulus(input logic ss, input logic lc, input logic tk);
      btn_ss  = ss;
      btn_lc  = lc;
      clk10ms = tk;
      @(posedge clk);
      #1;
      btn_ss  = 1'b0;
      btn_lc  = 1'b0;
      clk10ms = 1'b0;
   endtask

   task automatic doTicks(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Loads the count directly; only used while stopped so nothing else writes it
   task automatic preload(input logic [23:0] v);
      preload_val = v;
      force dut.count = preload_val;
      applyStimulus(1'b0, 1'b0, 1'b0);
      release dut.count;
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #5;
      checks++;
      if ({gen_rst, running, lap_hold, ovf} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 0000", {gen_rst, running, lap_hold, ovf});
      end
      checks++;
      if (disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL reset_disp: got %h expected 000000", disp_all);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if ({gen_rst, running} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_lc_ignored: got %b expected 00", {gen_rst, running});
      end
      doTicks(3);
      checks++;
      if (disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL idle_no_count: got %h expected 000000", disp_all);
      end
   endtask

   task automatic test_run;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++;
      if ({gen_rst, running, lap_hold} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL run_flags: got %b expected 110", {gen_rst, running, lap_hold});
      end
      doTicks(150);
      checks++;
      if (disp_all !== 24'h000150) begin
         errors++;
         $display("[TB] FAIL run_150: got %h expected 000150", disp_all);
      end
      checks++;
      if ({gen_rst, running} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL run_150_flags: got %b expected 11", {gen_rst, running});
      end
   endtask

   task automatic test_lap;
      doTicks(350);
      checks++;
      if (disp_all !== 24'h000500) begin
         errors++;
         $display("[TB] FAIL lap_pre: got %h expected 000500", disp_all);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if ({lap_hold, running} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL lap_enter: got %b expected 11", {lap_hold, running});
      end
      doTicks(30);
      checks++;
      if (disp_all !== 24'h000500 || lap_hold !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lap_frozen: got %h/%b expected 000500/1", disp_all, lap_hold);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (lap_hold !== 1'b0 || disp_all !== 24'h000500) begin
         errors++;
         $display("[TB] FAIL lap_exit_edge: got %h/%b expected 000500/0", disp_all, lap_hold);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (disp_all !== 24'h000530) begin
         errors++;
         $display("[TB] FAIL lap_exit_live: got %h expected 000530", disp_all);
      end
   endtask

   task automatic test_both_buttons;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checks++;
      if ({running, lap_hold, gen_rst} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL both_to_stop: got %b expected 001", {running, lap_hold, gen_rst});
      end
      doTicks(5);
      checks++;
      if (disp_all !== 24'h000530) begin
         errors++;
         $display("[TB] FAIL stop_retained: got %h expected 000530", disp_all);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if ({gen_rst, running} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL clear_flags: got %b expected 00", {gen_rst, running});
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL clear_disp: got %h expected 000000", disp_all);
      end
   endtask

   task automatic test_tick_stop;
      applyStimulus(1'b1, 1'b0, 1'b0);
      doTicks(9);
      checks++;
      if (disp_all !== 24'h000009) begin
         errors++;
         $display("[TB] FAIL tick_pre: got %h expected 000009", disp_all);
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tick_stop_state: got %b expected 0", running);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (disp_all !== 24'h000010) begin
         errors++;
         $display("[TB] FAIL tick_stop_disp: got %h expected 000010", disp_all);
      end
      doTicks(4);
      checks++;
      if (disp_all !== 24'h000010) begin
         errors++;
         $display("[TB] FAIL stop_no_count: got %h expected 000010", disp_all);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      doTicks(1);
      checks++;
      if (disp_all !== 24'h000011 || running !== 1'b1) begin
         errors++;
         $display("[TB] FAIL resume: got %h/%b expected 000011/1", disp_all, running);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      preload(24'h095999);
      applyStimulus(1'b1, 1'b0, 1'b0);
      doTicks(1);
      checks++;
      if (disp_all !== 24'h100000 || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL carry_min_tens: got %h/%b expected 100000/0", disp_all, ovf);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      preload(24'h595999);
      checks++;
      if (disp_all !== 24'h595999) begin
         errors++;
         $display("[TB] FAIL preload: got %h expected 595999", disp_all);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_idle: got %b expected 0", ovf);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_pulse: got %b expected 1", ovf);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (ovf !== 1'b0 || disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL ovf_after: got %b/%h expected 0/000000", ovf, disp_all);
      end
      doTicks(2);
      checks++;
      if (disp_all !== 24'h000002 || running !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_continue: got %h/%b expected 000002/1", disp_all, running);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset;
      applyStimulus(1'b1, 1'b0, 1'b0);
      doTicks(1234);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if (disp_all !== 24'h001234 || lap_hold !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lap_1234: got %h/%b expected 001234/1", disp_all, lap_hold);
      end
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({gen_rst, running, lap_hold, ovf} !== 4'b0000 || disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL async_reset: got %b/%h expected 0000/000000",
                  {gen_rst, running, lap_hold, ovf}, disp_all);
      end
      #2;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checks++;
      if ({gen_rst, running, lap_hold} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL post_reset_lc: got %b expected 000", {gen_rst, running, lap_hold});
      end
      doTicks(2);
      checks++;
      if (disp_all !== 24'h000000) begin
         errors++;
         $display("[TB] FAIL post_reset_disp: got %h expected 000000", disp_all);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      clk10ms = 1'b0;
      btn_ss  = 1'b0;
      btn_lc  = 1'b0;
      preload_val = 24'h000000;
      test_reset();
      test_run();
      test_lap();
      test_both_buttons();
      test_tick_stop();
      test_overflow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
